// File: rtl/alphabet_set_multiplier.sv
// Nibble-serial approximate multiplier: precomputes the {1x,3x,5x,7x} alphabet bank of A,
// then accumulates one shifted bank entry per multiplier nibble using external sel/sl codes.
module alphabet_set_multiplier #(
    parameter int LOG2_WIDTH        = 3,
    parameter int WIDTH             = 2 ** LOG2_WIDTH,
    parameter int LOG2_NIBBLE_WIDTH = 2,
    parameter int NIBBLE_WIDTH      = 2 ** LOG2_NIBBLE_WIDTH,
    parameter int NUM_NIBBLES       = WIDTH / NIBBLE_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             multiplicand,
    input  logic [WIDTH-1:0]             multiplier,
    output logic [NIBBLE_WIDTH-1:0]      nibble,
    input  logic [LOG2_NIBBLE_WIDTH-1:0] sel,
    input  logic [LOG2_NIBBLE_WIDTH-1:0] sl,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*WIDTH-1:0]           product
);

    localparam int BANK_W = WIDTH + 3;
    localparam int PROD_W = 2 * WIDTH;
    localparam int IDX_W  = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
    localparam int SH_W   = LOG2_WIDTH + 2;

    // Handshakes: a transfer happens at a rising edge where valid and ready are both high;
    // valid-side data is held stable until that edge.
    typedef enum logic [1:0] {IDLE, PRECOMP, ACCUM, DONE} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [BANK_W-1:0]   bank_q [4];
    logic [BANK_W-1:0]   bank_d [4];
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic [SH_W-1:0]         nib_shift;
    logic [SH_W-1:0]         shamt;
    logic [NIBBLE_WIDTH-1:0] nibble_cur;
    logic [PROD_W-1:0]       bank_ext;
    logic [PROD_W-1:0]       pp;
    logic [BANK_W-1:0]       a_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            for (int i = 0; i < 4; i++) bank_q[i] <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            for (int i = 0; i < 4; i++) bank_q[i] <= bank_d[i];
        end
    end

    // The decoder maps a zero nibble to 1x<<0, so the partial product is forced to zero.
    always_comb begin
        nib_shift  = SH_W'(idx_q) << LOG2_NIBBLE_WIDTH;
        shamt      = SH_W'(sl) + nib_shift;
        nibble_cur = NIBBLE_WIDTH'(b_q >> nib_shift);
        bank_ext   = PROD_W'(bank_q[sel]);
        pp         = (nibble_cur == '0) ? '0 : (bank_ext << shamt);
        a_ext      = BANK_W'(a_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        for (int i = 0; i < 4; i++) bank_d[i] = bank_q[i];
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = multiplicand;
                    b_d     = multiplier;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = PRECOMP;
                end
            end
            PRECOMP: begin
                bank_d[0] = a_ext;
                bank_d[1] = (a_ext << 1) + a_ext;
                bank_d[2] = (a_ext << 2) + a_ext;
                bank_d[3] = (a_ext << 3) - a_ext;
                state_d   = ACCUM;
            end
            ACCUM: begin
                acc_d = acc_q + pp;
                if (idx_q == IDX_W'(NUM_NIBBLES - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        product   = (state_q == DONE) ? acc_q : '0;
        nibble    = (state_q == ACCUM) ? nibble_cur : '0;
    end

endmodule
